// File: rtl/avl_bus_burst_arbiter_pkg.sv
// Shared types and sizing for the avl burst arbiter: burst-count width,
// arbitration state encoding and the muxed command payload.
package avl_bus_burst_arbiter_pkg;

  localparam int unsigned ALV_BURST_MAX_COUNT = 8;
  localparam int unsigned BURST_W             = $clog2(ALV_BURST_MAX_COUNT) + 1;

  localparam int unsigned MASTER_NUM_DEF = 4;
  localparam int unsigned ID_W_DEF       = $clog2(MASTER_NUM_DEF);

  typedef logic [ID_W_DEF-1:0] master_id_t;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // One command beat as presented to the shared slave.
  typedef struct packed {
    logic [31:0]        address;
    logic [3:0]         byte_en;
    logic [31:0]        write_data;
    logic               begin_burst;
    logic [BURST_W-1:0] burst_count;
  } avl_cmd_t;

endpackage

// File: rtl/avl_bus_burst_arbiter_if.sv
// Upstream (per-master) and downstream (shared slave) avl signals seen by the arbiter.
interface avl_bus_burst_arbiter_if #(
  parameter int unsigned MASTER_NUM = 4
);

  localparam int unsigned BW = avl_bus_burst_arbiter_pkg::BURST_W;

  logic [MASTER_NUM-1:0][31:0] m_address;
  logic [MASTER_NUM-1:0][3:0]  m_byte_en;
  logic [MASTER_NUM-1:0]       m_read;
  logic [MASTER_NUM-1:0]       m_write;
  logic [MASTER_NUM-1:0][31:0] m_write_data;
  logic [MASTER_NUM-1:0]       m_begin_burst_transfer;
  logic [MASTER_NUM-1:0][BW-1:0] m_burst_count;
  logic [MASTER_NUM-1:0]       m_request_ready;
  logic [MASTER_NUM-1:0]       m_resp_ready;
  logic [31:0]                 m_read_data;
  logic [MASTER_NUM-1:0]       m_read_data_valid;

  logic [31:0]   s_address;
  logic [3:0]    s_byte_en;
  logic          s_read;
  logic          s_write;
  logic [31:0]   s_write_data;
  logic          s_begin_burst_transfer;
  logic [BW-1:0] s_burst_count;
  logic          s_request_ready;
  logic          s_resp_ready;
  logic [31:0]   s_read_data;
  logic          s_read_data_valid;
  logic          err_unexpected_resp;

  // Arbiter faces the masters as their slave.
  modport slave (
    input  m_address, m_byte_en, m_read, m_write, m_write_data,
           m_begin_burst_transfer, m_burst_count, m_resp_ready,
    output m_request_ready, m_read_data, m_read_data_valid
  );

  // Arbiter drives the shared slave as its master.
  modport master (
    output s_address, s_byte_en, s_read, s_write, s_write_data,
           s_begin_burst_transfer, s_burst_count, s_resp_ready,
           err_unexpected_resp,
    input  s_request_ready, s_read_data, s_read_data_valid
  );

endinterface

// File: rtl/avl_bus_burst_arbiter_id_fifo.sv
// In-order FIFO of master IDs for outstanding reads; head selects the response target.
module avl_bus_burst_arbiter_id_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ID_W  = 2
) (
  input  logic            clk,
  input  logic            rest,
  input  logic            push_i,
  input  logic [ID_W-1:0] push_id_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [ID_W-1:0] head_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [ID_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full_d, empty_d;
  logic            push_ok, pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_o   <= 1'b0;
      empty_o  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_o   <= full_d;
      empty_o  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_id_i;
  end

  assign head_c_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/avl_bus_burst_arbiter.sv
// N-master to 1-slave avl arbiter: round-robin grant, burst lock, and in-order
// read-response routing through a master-ID FIFO. Command path is combinational.
module avl_bus_burst_arbiter
  import avl_bus_burst_arbiter_pkg::*;
#(
  parameter int unsigned MASTER_NUM      = 4,
  parameter int unsigned RESP_FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic rest,
  avl_bus_burst_arbiter_if.slave  m_bus,
  avl_bus_burst_arbiter_if.master s_bus
);

  localparam int unsigned ID_W = $clog2(MASTER_NUM);

  arb_state_t          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [BURST_W-1:0]  remain_q, remain_d;
  logic                err_q, err_d;

  logic [MASTER_NUM-1:0] req;
  logic [ID_W-1:0]       arb_gnt, gnt;
  logic                  arb_any, gnt_vld;
  logic                  rd_blocked, cmd_ok, accept, push, pop;
  logic                  fifo_full, fifo_empty, resp_rdy;
  logic [ID_W-1:0]       head;
  logic [MASTER_NUM-1:0] req_rdy, rd_vld;
  avl_cmd_t              sel;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (32'(id) == MASTER_NUM - 1) ? '0 : id + ID_W'(1);
  endfunction

  assign req = m_bus.m_read | m_bus.m_write;

  // Round-robin scan starting at rr_ptr with wrap.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    arb_any = 1'b0;
    arb_gnt = '0;
    for (int unsigned k = 0; k < MASTER_NUM; k++) begin
      idx = (32'(rr_ptr_q) + k) % MASTER_NUM;
      if (!arb_any && req[ID_W'(idx)]) begin
        arb_any = 1'b1;
        arb_gnt = ID_W'(idx);
      end
    end
  end

  // A locked burst owns the slave even while its master is idle.
  always_comb begin
    gnt     = arb_gnt;
    gnt_vld = arb_any;
    if (state_q == LOCK) begin
      gnt     = owner_q;
      gnt_vld = 1'b1;
    end
  end

  // A full FIFO blocks reads outright; a same-cycle pop does not bypass.
  assign rd_blocked = m_bus.m_read[gnt] && fifo_full;
  assign cmd_ok     = gnt_vld && !rd_blocked;
  assign accept     = cmd_ok && req[gnt] && s_bus.s_request_ready;
  assign push       = accept && m_bus.m_read[gnt];

  always_comb begin
    sel.address     = m_bus.m_address[gnt];
    sel.byte_en     = m_bus.m_byte_en[gnt];
    sel.write_data  = m_bus.m_write_data[gnt];
    sel.begin_burst = m_bus.m_begin_burst_transfer[gnt];
    sel.burst_count = m_bus.m_burst_count[gnt];
  end

  always_comb begin
    req_rdy      = '0;
    req_rdy[gnt] = cmd_ok && s_bus.s_request_ready;
  end

  assign s_bus.s_address              = sel.address;
  assign s_bus.s_byte_en              = sel.byte_en;
  assign s_bus.s_write_data           = sel.write_data;
  assign s_bus.s_begin_burst_transfer = sel.begin_burst;
  assign s_bus.s_burst_count          = sel.burst_count;
  assign s_bus.s_read                 = cmd_ok && m_bus.m_read[gnt];
  assign s_bus.s_write                = cmd_ok && m_bus.m_write[gnt];
  assign m_bus.m_request_ready        = req_rdy;

  // Arbitration state machine: next state.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    remain_d = remain_q;
    err_d    = err_q | (s_bus.s_read_data_valid && fifo_empty);
    case (state_q)
      ARB: begin
        if (accept) begin
          if (sel.begin_burst && (sel.burst_count != '0)) begin
            state_d  = LOCK;
            owner_d  = gnt;
            remain_d = sel.burst_count;
          end else begin
            rr_ptr_d = next_id(gnt);
          end
        end
      end
      LOCK: begin
        if (accept) begin
          if (remain_q == BURST_W'(1)) begin
            state_d  = ARB;
            remain_d = '0;
            rr_ptr_d = next_id(owner_q);
          end else begin
            remain_d = remain_q - BURST_W'(1);
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      remain_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      remain_q <= remain_d;
      err_q    <= err_d;
    end
  end

  avl_bus_burst_arbiter_id_fifo #(
    .DEPTH (RESP_FIFO_DEPTH),
    .ID_W  (ID_W)
  ) u_id_fifo (
    .clk       (clk),
    .rest      (rest),
    .push_i    (push),
    .push_id_i (gnt),
    .pop_i     (pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_c_o  (head)
  );

  // Responses go to the FIFO head only; data is broadcast.
  assign resp_rdy = !fifo_empty && m_bus.m_resp_ready[head];
  assign pop      = s_bus.s_read_data_valid && resp_rdy;

  always_comb begin
    rd_vld       = '0;
    rd_vld[head] = s_bus.s_read_data_valid && !fifo_empty;
  end

  assign s_bus.s_resp_ready        = resp_rdy;
  assign m_bus.m_read_data_valid   = rd_vld;
  assign m_bus.m_read_data         = s_bus.s_read_data;
  assign s_bus.err_unexpected_resp = err_q;

endmodule

// File: tb/tb_avl_bus_burst_arbiter.sv
// Directed self-checking bench for avl_bus_burst_arbiter with four masters.
module tb_avl_bus_burst_arbiter;

  logic clk;
  logic rest;
  int   n_cmp;
  int   n_err;

  avl_bus_burst_arbiter_if #(.MASTER_NUM(4)) bus ();

  avl_bus_burst_arbiter #(
    .MASTER_NUM      (4),
    .RESP_FIFO_DEPTH (8)
  ) dut (
    .clk   (clk),
    .rest  (rest),
    .m_bus (bus),
    .s_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.m_address              = '0;
    bus.m_byte_en              = '0;
    bus.m_read                 = '0;
    bus.m_write                = '0;
    bus.m_write_data           = '0;
    bus.m_begin_burst_transfer = '0;
    bus.m_burst_count          = '0;
    bus.m_resp_ready           = '0;
    bus.s_request_ready        = 1'b0;
    bus.s_read_data            = '0;
    bus.s_read_data_valid      = 1'b0;
  endtask

  task automatic reset_dut();
    idle_all();
    rest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rest = 1'b1;
  endtask

  task automatic test_reset();
    idle_all();
    rest = 1'b0;
    #1;
    n_cmp++; if (bus.m_request_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_rdy got=%b exp=0000", bus.m_request_ready); end
    n_cmp++; if (bus.m_read_data_valid !== 4'b0000) begin n_err++; $display("FAIL reset_rd_vld got=%b exp=0000", bus.m_read_data_valid); end
    n_cmp++; if (bus.s_read !== 1'b0 || bus.s_write !== 1'b0) begin n_err++; $display("FAIL reset_s_rw got=%b%b exp=00", bus.s_read, bus.s_write); end
    n_cmp++; if (bus.s_resp_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_resp_rdy got=%b exp=0", bus.s_resp_ready); end
    n_cmp++; if (bus.err_unexpected_resp !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", bus.err_unexpected_resp); end
    reset_dut();
  endtask

  task automatic test_rr_fairness();
    logic [3:0]  exp_rdy;
    logic [31:0] exp_addr;
    reset_dut();
    bus.s_request_ready = 1'b1;
    bus.m_write         = 4'b1111;
    bus.m_address       = {32'h1030, 32'h1020, 32'h1010, 32'h1000};
    for (int c = 0; c < 9; c++) begin
      exp_rdy  = 4'b0001 << (c % 4);
      exp_addr = 32'h1000 + 32'(c % 4) * 32'h10;
      #1;
      n_cmp++; if (bus.m_request_ready !== exp_rdy) begin n_err++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus.m_request_ready, exp_rdy); end
      n_cmp++; if (bus.s_address !== exp_addr || bus.s_write !== 1'b1) begin n_err++; $display("FAIL rr_addr c=%0d got=%h/%b exp=%h/1", c, bus.s_address, bus.s_write, exp_addr); end
      tick();
    end
    idle_all();
  endtask

  task automatic test_burst_lock();
    logic [31:0] exp_addr;
    reset_dut();
    bus.s_request_ready = 1'b1;
    bus.m_write[0] = 1'b1; bus.m_address[0] = 32'h0000_0000;
    bus.m_write[2] = 1'b1; bus.m_address[2] = 32'h0000_0200;
    bus.m_read[1]  = 1'b1; bus.m_address[1] = 32'h0000_0100;
    bus.m_begin_burst_transfer[1] = 1'b1; bus.m_burst_count[1] = 4'd3;
    #1;
    n_cmp++; if (bus.m_request_ready !== 4'b0001) begin n_err++; $display("FAIL burst_first_m0 got=%b exp=0001", bus.m_request_ready); end
    tick();
    for (int b = 0; b < 4; b++) begin
      exp_addr = 32'h100 + 32'(b) * 32'h4;
      bus.m_address[1] = exp_addr;
      bus.m_burst_count[1] = 4'(3 - b);
      bus.m_begin_burst_transfer[1] = (b == 0);
      #1;
      n_cmp++; if (bus.m_request_ready !== 4'b0010) begin n_err++; $display("FAIL burst_beat_rdy b=%0d got=%b exp=0010", b, bus.m_request_ready); end
      n_cmp++; if (bus.s_address !== exp_addr || bus.s_read !== 1'b1) begin n_err++; $display("FAIL burst_beat_addr b=%0d got=%h/%b exp=%h/1", b, bus.s_address, bus.s_read, exp_addr); end
      tick();
      if (b == 1) begin
        bus.m_read[1] = 1'b0;
        #1;
        n_cmp++; if (bus.m_request_ready !== 4'b0010 || bus.s_write !== 1'b0) begin n_err++; $display("FAIL burst_idle_owner got=%b/%b exp=0010/0", bus.m_request_ready, bus.s_write); end
        tick();
        bus.m_read[1] = 1'b1;
      end
    end
    bus.m_read[1] = 1'b0;
    #1;
    n_cmp++; if (bus.m_request_ready !== 4'b0100 || bus.s_address !== 32'h200) begin n_err++; $display("FAIL burst_next_m2 got=%b/%h exp=0100/00000200", bus.m_request_ready, bus.s_address); end
    tick();
    idle_all();
    bus.m_resp_ready      = 4'b1111;
    bus.s_read_data_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.s_read_data = 32'h5000 + 32'(k);
      #1;
      n_cmp++; if (bus.m_read_data_valid !== 4'b0010 || bus.m_read_data !== 32'h5000 + 32'(k)) begin n_err++; $display("FAIL burst_fifo_id k=%0d got=%b/%h exp=0010/%h", k, bus.m_read_data_valid, bus.m_read_data, 32'h5000 + 32'(k)); end
      tick();
    end
    bus.s_read_data_valid = 1'b0;
    #1;
    n_cmp++; if (bus.s_resp_ready !== 1'b0) begin n_err++; $display("FAIL burst_fifo_drained got=%b exp=0", bus.s_resp_ready); end
    idle_all();
  endtask

  task automatic test_backpressure();
    reset_dut();
    bus.m_write[2] = 1'b1;
    bus.m_address[2] = 32'h2220;
    bus.m_write_data[2] = 32'hDEAD_BEEF;
    bus.s_request_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (bus.s_write !== 1'b1 || bus.s_address !== 32'h2220 || bus.s_write_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL bp_hold c=%0d got=%b/%h/%h exp=1/00002220/deadbeef", c, bus.s_write, bus.s_address, bus.s_write_data); end
      n_cmp++; if (bus.m_request_ready !== 4'b0000) begin n_err++; $display("FAIL bp_no_rdy c=%0d got=%b exp=0000", c, bus.m_request_ready); end
      tick();
    end
    bus.s_request_ready = 1'b1;
    #1;
    n_cmp++; if (bus.m_request_ready !== 4'b0100) begin n_err++; $display("FAIL bp_release got=%b exp=0100", bus.m_request_ready); end
    tick();
    idle_all();
  endtask

  task automatic test_fifo_full();
    reset_dut();
    bus.s_request_ready = 1'b1;
    bus.m_read[0] = 1'b1;
    bus.m_address[0] = 32'h40;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++; if (bus.m_request_ready !== 4'b0001) begin n_err++; $display("FAIL full_fill k=%0d got=%b exp=0001", k, bus.m_request_ready); end
      tick();
    end
    #1;
    n_cmp++; if (bus.m_request_ready !== 4'b0000 || bus.s_read !== 1'b0) begin n_err++; $display("FAIL full_block got=%b/%b exp=0000/0", bus.m_request_ready, bus.s_read); end
    tick();
    bus.m_resp_ready[0] = 1'b1;
    bus.s_read_data_valid = 1'b1;
    bus.s_read_data = 32'h0000_0F0F;
    #1;
    n_cmp++; if (bus.s_resp_ready !== 1'b1 || bus.m_read_data_valid !== 4'b0001) begin n_err++; $display("FAIL full_pop got=%b/%b exp=1/0001", bus.s_resp_ready, bus.m_read_data_valid); end
    n_cmp++; if (bus.m_request_ready !== 4'b0000 || bus.s_read !== 1'b0) begin n_err++; $display("FAIL full_no_bypass got=%b/%b exp=0000/0", bus.m_request_ready, bus.s_read); end
    tick();
    bus.s_read_data_valid = 1'b0;
    #1;
    n_cmp++; if (bus.m_request_ready !== 4'b0001 || bus.s_read !== 1'b1) begin n_err++; $display("FAIL full_unblock got=%b/%b exp=0001/1", bus.m_request_ready, bus.s_read); end
    tick();
    idle_all();
  endtask

  task automatic test_routing();
    reset_dut();
    bus.s_request_ready = 1'b1;
    bus.m_read = 4'b0100;
    #1;
    n_cmp++; if (bus.m_request_ready !== 4'b0100) begin n_err++; $display("FAIL route_issue_m2 got=%b exp=0100", bus.m_request_ready); end
    tick();
    bus.m_read = 4'b0001;
    #1;
    n_cmp++; if (bus.m_request_ready !== 4'b0001) begin n_err++; $display("FAIL route_issue_m0 got=%b exp=0001", bus.m_request_ready); end
    tick();
    bus.m_read = 4'b1000;
    #1;
    n_cmp++; if (bus.m_request_ready !== 4'b1000) begin n_err++; $display("FAIL route_issue_m3 got=%b exp=1000", bus.m_request_ready); end
    tick();
    bus.m_read = 4'b0000;
    bus.m_resp_ready = 4'b1110;
    bus.s_read_data_valid = 1'b1;
    bus.s_read_data = 32'hAAAA_0002;
    #1;
    n_cmp++; if (bus.m_read_data_valid !== 4'b0100 || bus.s_resp_ready !== 1'b1 || bus.m_read_data !== 32'hAAAA_0002) begin n_err++; $display("FAIL route_m2 got=%b/%b/%h exp=0100/1/aaaa0002", bus.m_read_data_valid, bus.s_resp_ready, bus.m_read_data); end
    tick();
    bus.s_read_data = 32'hBBBB_0000;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (bus.s_resp_ready !== 1'b0 || bus.m_read_data_valid !== 4'b0001) begin n_err++; $display("FAIL route_m0_wait c=%0d got=%b/%b exp=0/0001", c, bus.s_resp_ready, bus.m_read_data_valid); end
      tick();
    end
    bus.m_resp_ready = 4'b1111;
    #1;
    n_cmp++; if (bus.s_resp_ready !== 1'b1 || bus.m_read_data_valid !== 4'b0001) begin n_err++; $display("FAIL route_m0 got=%b/%b exp=1/0001", bus.s_resp_ready, bus.m_read_data_valid); end
    tick();
    bus.s_read_data = 32'hCCCC_0003;
    #1;
    n_cmp++; if (bus.m_read_data_valid !== 4'b1000) begin n_err++; $display("FAIL route_m3 got=%b exp=1000", bus.m_read_data_valid); end
    tick();
    bus.s_read_data_valid = 1'b0;
    #1;
    n_cmp++; if (bus.s_resp_ready !== 1'b0 || bus.err_unexpected_resp !== 1'b0) begin n_err++; $display("FAIL route_drained got=%b/%b exp=0/0", bus.s_resp_ready, bus.err_unexpected_resp); end
    idle_all();
  endtask

  task automatic test_error_reset();
    reset_dut();
    bus.m_resp_ready = 4'b1111;
    bus.s_read_data_valid = 1'b1;
    #1;
    n_cmp++; if (bus.m_read_data_valid !== 4'b0000 || bus.s_resp_ready !== 1'b0) begin n_err++; $display("FAIL err_ignored got=%b/%b exp=0000/0", bus.m_read_data_valid, bus.s_resp_ready); end
    tick();
    bus.s_read_data_valid = 1'b0;
    #1;
    n_cmp++; if (bus.err_unexpected_resp !== 1'b1) begin n_err++; $display("FAIL err_set got=%b exp=1", bus.err_unexpected_resp); end
    repeat (3) tick();
    n_cmp++; if (bus.err_unexpected_resp !== 1'b1) begin n_err++; $display("FAIL err_sticky got=%b exp=1", bus.err_unexpected_resp); end
    bus.s_request_ready = 1'b1;
    bus.m_read[1] = 1'b1;
    bus.m_address[1] = 32'h300;
    bus.m_begin_burst_transfer[1] = 1'b1;
    bus.m_burst_count[1] = 4'd3;
    tick();
    bus.m_read[1] = 1'b0;
    bus.m_write[0] = 1'b1;
    #1;
    n_cmp++; if (bus.m_request_ready !== 4'b0010 || bus.s_write !== 1'b0) begin n_err++; $display("FAIL rst_locked got=%b/%b exp=0010/0", bus.m_request_ready, bus.s_write); end
    bus.m_write = '0;
    rest = 1'b0;
    #1;
    n_cmp++; if (bus.err_unexpected_resp !== 1'b0 || bus.s_resp_ready !== 1'b0 || bus.m_request_ready !== 4'b0000) begin n_err++; $display("FAIL rst_async got=%b/%b/%b exp=0/0/0000", bus.err_unexpected_resp, bus.s_resp_ready, bus.m_request_ready); end
    tick();
    rest = 1'b1;
    bus.m_write[0] = 1'b1;
    #1;
    n_cmp++; if (bus.m_request_ready !== 4'b0001 || bus.s_resp_ready !== 1'b0) begin n_err++; $display("FAIL rst_unlocked got=%b/%b exp=0001/0", bus.m_request_ready, bus.s_resp_ready); end
    tick();
    idle_all();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rest  = 1'b0;
    idle_all();
    @(posedge clk);
    #1;
    test_reset();
    test_rr_fairness();
    test_burst_lock();
    test_backpressure();
    test_fifo_full();
    test_routing();
    test_error_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
